// File: rtl/parity_link_pkg.sv
// Shared types and constants for the 3-bit even-parity serial link.
// Frame on the wire: start(0), d0, d1, d2, parity, stop(1).
package parity_link_pkg;

  localparam int DATA_W     = 3;
  localparam int FRAME_BITS = 6;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/parity_frame_rx.sv
// Receive half of the link: two-flop line synchronizer, frame FSM and the
// registered RX outputs. Bits are sampled mid-bit, timed from the start edge.
module parity_frame_rx
  import parity_link_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              rx_ferr
);

  localparam int CNT_W   = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W   = $clog2(DATA_W);
  localparam int SHIFT_W = FRAME_BITS - 2;

  logic               r_sync1;
  logic               r_sync2;
  rx_state_t          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [SHIFT_W-1:0] r_shift;

  logic w_line;
  logic w_half;
  logic w_bit_end;

  assign w_line    = r_sync2;
  assign w_half    = (r_cnt == CNT_W'(BIT_CYCLES / 2 - 1));
  assign w_bit_end = (r_cnt == CNT_W'(BIT_CYCLES - 1));

  // NOTE: the synchronizer resets to 1 (idle line) so leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      rx_data   <= '0;
      rx_parity <= 1'b0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      r_sync1  <= ser_in;
      r_sync2  <= r_sync1;
      rx_valid <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!w_line) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (w_half) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_line ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA, RX_PAR: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            // Shift in from the top so d0 ends in bit 0 and parity on top.
            r_shift <= {w_line, r_shift[SHIFT_W-1:1]};
            if (r_state == RX_PAR) begin
              r_state <= RX_STOP;
            end else if (r_idx == IDX_W'(DATA_W - 1)) begin
              r_state <= RX_PAR;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            rx_data   <= r_shift[DATA_W-1:0];
            rx_parity <= r_shift[SHIFT_W-1];
            rx_err    <= ^r_shift;
            rx_ferr   <= ~w_line;
            rx_valid  <= 1'b1;
            r_state   <= w_line ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (w_line) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parity_link_ctrl.sv
// Serial parity link controller: TX framing FSM and saturating parity-error
// counter here; the receive path lives in parity_frame_rx.
module parity_link_ctrl
  import parity_link_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 ser_out,
  input  logic                 ser_in,
  output logic [DATA_W-1:0]    rx_data,
  output logic                 rx_parity,
  output logic                 rx_valid,
  output logic                 rx_err,
  output logic                 rx_ferr,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  localparam int CNT_W   = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W   = $clog2(DATA_W);
  localparam int SHIFT_W = FRAME_BITS - 2;

  tx_state_t          r_tx_state;
  logic [CNT_W-1:0]   r_tx_cnt;
  logic [IDX_W-1:0]   r_tx_idx;
  logic [SHIFT_W-1:0] r_tx_shift;

  logic w_tx_bit_end;
  logic w_accept;
  logic w_err_inc;

  assign tx_ready     = (r_tx_state == TX_IDLE);
  assign w_accept     = tx_valid & tx_ready;
  assign w_tx_bit_end = (r_tx_cnt == CNT_W'(BIT_CYCLES - 1));
  assign w_err_inc    = rx_valid & rx_err;

  // NOTE: ser_out is loaded with the next bit at each bit boundary, so the line is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      ser_out    <= 1'b1;
    end else if (r_tx_state == TX_IDLE) begin
      if (w_accept) begin
        r_tx_state <= TX_START;
        r_tx_cnt   <= '0;
        r_tx_shift <= {even_parity(tx_data), tx_data};
        ser_out    <= 1'b0;
      end
    end else begin
      r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
      if (w_tx_bit_end) begin
        case (r_tx_state)
          TX_START: begin
            r_tx_state <= TX_DATA;
            r_tx_idx   <= '0;
            ser_out    <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
          end
          TX_DATA: begin
            // After the last data bit, bit 0 of the shifter holds the parity.
            ser_out    <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            if (r_tx_idx == IDX_W'(DATA_W - 1)) r_tx_state <= TX_PAR;
            else                                r_tx_idx   <= r_tx_idx + 1'b1;
          end
          TX_PAR: begin
            r_tx_state <= TX_STOP;
            ser_out    <= 1'b1;
          end
          default: r_tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // A clear that coincides with an error keeps that error: the count becomes 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= w_err_inc ? ERR_CNT_W'(1) : '0;
    end else if (w_err_inc && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

  parity_frame_rx #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .rx_data   (rx_data),
    .rx_parity (rx_parity),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .rx_ferr   (rx_ferr)
  );

endmodule

// File: doc/parity_link_ctrl.md
# parity_link_ctrl

Serial link controller that sequences the 3-bit even-parity generate/check datapath over a single-wire frame. The transmit side accepts a 3-bit word by valid/ready, appends even parity and serializes the frame. The receive side deserializes an incoming frame, checks parity and stop bit, and keeps a saturating parity-error count. It sits between the lab's parallel parity generator/checker logic and an off-block serial line.

## Interface
- `BIT_CYCLES`, 4: clock cycles per serial bit; must be ≥ 2.
- `ERR_CNT_W`, 8: width of the parity-error counter.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `tx_data` in 3: word to send; bit 0 is sent first.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: transmitter idle and able to accept; reset value 1.
- `ser_out` out 1: serial line, idle high; reset value 1.
- `ser_in` in 1: serial line input, asynchronous to frame timing.
- `rx_data` out 3: last received word; reset value 0.
- `rx_parity` out 1: last received parity bit; reset value 0.
- `rx_valid` out 1: one-cycle pulse, RX outputs updated; reset value 0.
- `rx_err` out 1: parity mismatch, defined as `^{rx_data, rx_parity}` = 1; reset value 0.
- `rx_ferr` out 1: stop bit sampled low; reset value 0.
- `err_count` out ERR_CNT_W: saturating count of `rx_valid & rx_err`; reset value 0.
- `err_clr` in 1: synchronous clear of `err_count`.

## Operation
- **Frame:** six bits, each BIT_CYCLES long, in this order: start(0), d0, d1, d2, parity, stop(1). Parity is even: `p = ^tx_data`.
- **TX FSM:** TX_IDLE → TX_START → TX_DATA (×3) → TX_PAR → TX_STOP → TX_IDLE.
  - `tx_ready` = 1 only in TX_IDLE.
  - The FSM accepts on `tx_valid & tx_ready` and latches data and parity at that edge.
  - `ser_out` is registered and is 1 in TX_IDLE.
- **Input synchronizer:** two flops on `ser_in`, both reset to 1. The RX side sees only the synchronized value.
- **RX FSM:** RX_IDLE → RX_START → RX_DATA (×3) → RX_PAR → RX_STOP → RX_IDLE. RX_WAIT_HIGH is an extra state.
  - RX_IDLE: a synchronized 0 enters RX_START with the bit counter cleared.
  - RX_START: at BIT_CYCLES/2 (integer division), samples the line. If it is 1, this is a false start and the FSM returns to RX_IDLE. If it is 0, the FSM proceeds.
  - Subsequent samples occur every BIT_CYCLES: d0, d1, d2, parity, stop.
  - At the stop-sample edge the FSM registers `rx_data`, `rx_parity`, `rx_err` and `rx_ferr = ~stop`. `rx_valid` is asserted for the following cycle.
  - If the stop bit is 1, the FSM goes to RX_IDLE. If it is 0, the FSM goes to RX_WAIT_HIGH and stays there until the synchronized line reads 1, then goes to RX_IDLE.
- **`err_count`:**
  - Increments on `rx_valid & rx_err` and holds at all-ones.
  - `err_clr` alone sets it to 0.
  - `err_clr` together with an increment sets it to 1.
- TX and RX are fully independent. Loopback (`ser_in = ser_out`) is legal.

## Timing
- **TX:**
  - For accept edge T: `ser_out` = 0 from T+1.
  - `tx_ready` returns to 1 at T+1+6·BIT_CYCLES. The FSM then spends at least one cycle in TX_IDLE.
  - Back-to-back frames with `tx_valid` held high give 6·BIT_CYCLES+1 cycles per frame.
- **RX:** let L be the edge where sync flop 1 first captures 0.
  - RX_START is entered at L+2.
  - The start-bit check occurs at L+2+BIT_CYCLES/2.
  - The stop bit is sampled at L+2+BIT_CYCLES/2+5·BIT_CYCLES.
  - `rx_valid` is high during the next cycle. With the default BIT_CYCLES = 4, that cycle begins at L+25.
- **Reset:** asserting `rst_n` at any point, including mid-frame, forces all outputs to their reset values immediately and both FSMs to IDLE. A partial frame is discarded, with no `rx_valid`.
- **RX outputs:** `rx_data`, `rx_parity`, `rx_err` and `rx_ferr` hold their values until the next `rx_valid`.

## Structure
- Package `parity_link_pkg` holds:
  - the TX and RX state enums;
  - `DATA_W` = 3;
  - `FRAME_BITS` = 6.
- Sub-module `parity_frame_rx` contains the synchronizer, the RX FSM and the RX output registers.
- The TX FSM and `err_count` stay in the top level.

## Test plan
- **Single frame:** loopback, BIT_CYCLES = 4, send 3'b101.
  - `ser_out` must read 0,1,0,1,0,1, each bit held 4 cycles.
  - `rx_valid` must pulse at L+25 with `rx_data` = 101, `rx_parity` = 0, `rx_err` = 0, `rx_ferr` = 0.
- **Word sweep:** loopback, send words 0 through 7 back-to-back with `tx_valid` held high.
  - Expect 8 `rx_valid` pulses with parities 0,1,1,0,1,0,0,1.
  - `err_count` must stay 0.
  - `tx_ready` must be low for exactly 24 cycles per frame.
- **Parity error:** drive `ser_in` directly with data 3'b011 and parity 1.
  - Expect `rx_err` = 1 and `err_count` = 1.
  - With ERR_CNT_W = 2 and 5 such frames, `err_count` must hold at 3.
- **Glitch:** pulse `ser_in` low for 1 cycle.
  - Expect no `rx_valid` and RX back in RX_IDLE.
  - A following valid frame must be received correctly.
- **Framing error:** send a frame with the stop bit at 0, then hold the line low for 10 bit times.
  - Expect exactly one `rx_valid` with `rx_ferr` = 1.
  - After the line returns high, the next frame must be received correctly.
- **Reset mid-frame and clear collision:**
  - Assert `rst_n` low during TX_DATA: `ser_out` = 1, `tx_ready` = 1 and `err_count` = 0 immediately, with no `rx_valid`.
  - Apply `err_clr` on the same cycle as an erroring `rx_valid`: `err_count` = 1.
